credit_tx_gate: RTL and testbench

Credit-gated transmit stage that drives a ConfigCounter instance as its client. It buffers outbound items in a small FIFO and releases one item per cycle only while the credit counter is non-zero, debiting one credit per item. It also coalesces credit returns from the far end into batched counter increments. It sits between the producer and the link, and owns the counter's decrement, increment and read ports.

---
 rtl/credit_tx_gate.sv | 194 +++++++++++++++++++
 tb/tb_credit_tx_gate.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/credit_tx_gate.sv
// Credit-gated transmit stage. Buffers producer items in a small FIFO and
// releases one per cycle while the external credit counter is non-zero,
// debiting one credit per item. Far-end credit returns are coalesced into
// batched increments of the same counter, flushed on a size threshold or
// after a bounded wait.
module credit_tx_gate #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 4,
  parameter int count_sz    = 10,
  parameter int RET_THRESH  = 4,
  parameter int RET_TIMEOUT = 8
) (
  input  logic                CLK,
  input  logic                nRST,
  // producer side
  input  logic                enq__ENA,
  input  logic [DATA_W-1:0]   enq_v,
  output logic                enq__RDY,
  // link side
  output logic                out__ENA,
  output logic [DATA_W-1:0]   out_v,
  input  logic                out__RDY,
  // credit returns from the far end
  input  logic                cred_ret__ENA,
  input  logic [count_sz-1:0] cred_ret_v,
  // credit counter client ports
  output logic                ctr_decrement__ENA,
  output logic [count_sz-1:0] ctr_decrement_v,
  input  logic                ctr_decrement__RDY,
  output logic                ctr_increment__ENA,
  output logic [count_sz-1:0] ctr_increment_v,
  input  logic                ctr_increment__RDY,
  input  logic [count_sz-1:0] ctr_read,
  input  logic                ctr_read__RDY,
  // sticky return-accumulator saturation flag
  output logic                ret_overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = (RET_TIMEOUT > 1) ? $clog2(RET_TIMEOUT) : 1;

  localparam logic [CNT_W-1:0]    FULL_CNT = CNT_W'(DEPTH);
  localparam logic [count_sz-1:0] THRESH   = count_sz'(RET_THRESH);
  localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(RET_TIMEOUT - 1);

  // Return FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // ---------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] mem_view [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              enq_fire;
  logic              deq_fire;
  logic              fifo_empty;

  // Full is judged on the registered occupancy only, so a pop in the same
  // cycle never opens a slot for a simultaneous push.
  assign enq__RDY   = (cnt_q < FULL_CNT);
  assign fifo_empty = (cnt_q == '0);
  assign enq_fire   = enq__ENA && enq__RDY;

  // Send gate: an item leaves only when the link, the counter read and the
  // counter debit port are all ready and at least one credit is available.
  assign out__ENA = !fifo_empty && out__RDY && (ctr_read != '0)
                    && ctr_read__RDY && ctr_decrement__RDY;
  assign deq_fire = out__ENA;
  assign out_v    = mem_view[rd_ptr_q];

  assign ctr_decrement__ENA = out__ENA;
  assign ctr_decrement_v    = count_sz'(1);

  // Per-entry storage; each slot captures the payload when the write
  // pointer selects it. Data is not reset, occupancy alone defines validity.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic              wr_en;
    logic [DATA_W-1:0] entry_q, entry_d;

    assign wr_en        = enq_fire && (wr_ptr_q == PTR_W'(gi));
    assign mem_view[gi] = entry_q;

    // Select new payload for this slot on a targeted push
    always_comb begin
      entry_d = entry_q;
      if (wr_en) entry_d = enq_v;
    end

    // Slot register
    always_ff @(posedge CLK) begin
      entry_q <= entry_d;
    end
  end

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (enq_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (deq_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({enq_fire, deq_fire})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO control registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Return accumulator
  // ---------------------------------------------------------------------
  logic [count_sz-1:0] acc_q, acc_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [1:0]          state_q, state_d;
  logic                ovf_q, ovf_d;
  logic                flush_fire;
  logic [count_sz:0]   acc_sum;

  assign flush_fire         = (state_q == ST_FLUSH) && ctr_increment__RDY;
  assign ctr_increment__ENA = flush_fire;
  assign ctr_increment_v    = acc_q;
  assign ret_overflow       = ovf_q;
  assign acc_sum            = {1'b0, acc_q} + {1'b0, cred_ret_v};

  // Accumulate, saturate and age returns; a flush hands the batch to the
  // counter and restarts with whatever arrives in the same cycle.
  always_comb begin
    acc_d   = acc_q;
    timer_d = timer_q;
    ovf_d   = ovf_q;
    if (flush_fire) begin
      acc_d   = cred_ret__ENA ? cred_ret_v : '0;
      timer_d = '0;
    end else begin
      if (cred_ret__ENA) begin
        if (acc_sum[count_sz]) begin
          acc_d = '1;
          ovf_d = 1'b1;
        end else begin
          acc_d = acc_sum[count_sz-1:0];
        end
      end
      if (acc_q == '0) begin
        timer_d = '0;
      end else if (timer_q != TMR_LAST) begin
        timer_d = timer_q + TMR_W'(1);
      end
    end
  end

  // Classify the next accumulator contents into IDLE / ACCUM / FLUSH
  always_comb begin
    state_d = ST_ACCUM;
    if (acc_d == '0) begin
      state_d = ST_IDLE;
    end else if ((acc_d >= THRESH) || (timer_d == TMR_LAST)) begin
      state_d = ST_FLUSH;
    end
  end

  // Return path registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      acc_q   <= '0;
      timer_q <= '0;
      state_q <= ST_IDLE;
      ovf_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      timer_q <= timer_d;
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_credit_tx_gate.sv
// Self-checking bench for credit_tx_gate: directed scenarios plus a random
// run, all compared against a queue/arithmetic reference model that also
// plays the role of the external credit counter.
module tb_credit_tx_gate;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CSZ   = 10;
  localparam int THR   = 4;
  localparam int TMO   = 8;
  localparam int MAXV  = 1023;

  logic           clk = 1'b0;
  logic           nrst = 1'b0;
  logic           enq_ena;
  logic [DW-1:0]  enq_v;
  logic           enq_rdy;
  logic           out_ena;
  logic [DW-1:0]  out_v;
  logic           out_rdy;
  logic           cr_ena;
  logic [CSZ-1:0] cr_v;
  logic           dec_ena;
  logic [CSZ-1:0] dec_v;
  logic           dec_rdy;
  logic           inc_ena;
  logic [CSZ-1:0] inc_v;
  logic           inc_rdy;
  logic [CSZ-1:0] ctr_read;
  logic           rd_rdy;
  logic           ovf;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // reference model state
  logic [DW-1:0] mq[$];
  int            m_acc;
  int            m_age;
  bit            m_ovf;
  int            credits;
  bit            e_enq_rdy, e_out_ena, e_inc_ena;
  logic [DW-1:0] e_out_v;

  assign ctr_read = CSZ'(credits);

  credit_tx_gate #(
    .DATA_W(DW), .DEPTH(DEPTH), .count_sz(CSZ),
    .RET_THRESH(THR), .RET_TIMEOUT(TMO)
  ) dut (
    .CLK                (clk),
    .nRST               (nrst),
    .enq__ENA           (enq_ena),
    .enq_v              (enq_v),
    .enq__RDY           (enq_rdy),
    .out__ENA           (out_ena),
    .out_v              (out_v),
    .out__RDY           (out_rdy),
    .cred_ret__ENA      (cr_ena),
    .cred_ret_v         (cr_v),
    .ctr_decrement__ENA (dec_ena),
    .ctr_decrement_v    (dec_v),
    .ctr_decrement__RDY (dec_rdy),
    .ctr_increment__ENA (inc_ena),
    .ctr_increment_v    (inc_v),
    .ctr_increment__RDY (inc_rdy),
    .ctr_read           (ctr_read),
    .ctr_read__RDY      (rd_rdy),
    .ret_overflow       (ovf)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    mq.delete();
    m_acc = 0;
    m_age = 0;
    m_ovf = 1'b0;
  endfunction

  // Expected outputs for the current cycle from the model and applied inputs
  function automatic void predict();
    e_enq_rdy = (mq.size() < DEPTH);
    e_out_ena = (mq.size() > 0) && out_rdy && (credits != 0) && rd_rdy && dec_rdy;
    e_out_v   = (mq.size() > 0) ? mq[0] : '0;
    e_inc_ena = inc_rdy && (m_acc != 0) && ((m_acc >= THR) || (m_age >= TMO - 1));
  endfunction

  // Cross one clock edge and apply its effect to the model and counter
  task automatic advance();
    int s;
    predict();
    @(posedge clk);
    #1;
    if (e_out_ena) begin
      void'(mq.pop_front());
      credits = credits - 1;
    end
    if (enq_ena && e_enq_rdy) mq.push_back(enq_v);
    if (e_inc_ena) begin
      credits = credits + m_acc;
      m_acc   = cr_ena ? int'(cr_v) : 0;
      m_age   = 0;
    end else begin
      s     = m_acc + (cr_ena ? int'(cr_v) : 0);
      m_age = (m_acc != 0) ? m_age + 1 : 0;
      if (s > MAXV) begin
        s     = MAXV;
        m_ovf = 1'b1;
      end
      m_acc = s;
    end
    cyc++;
  endtask

  task automatic idle_inputs();
    enq_ena = 1'b0; enq_v = '0; out_rdy = 1'b0;
    cr_ena = 1'b0; cr_v = '0;
    dec_rdy = 1'b1; inc_rdy = 1'b1; rd_rdy = 1'b1;
  endtask

  // Asynchronous reset applied and released away from the active edge
  task automatic do_reset();
    idle_inputs();
    #2 nrst = 1'b0;
    #2;
    model_reset();
    credits = 0;
    @(negedge clk) nrst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    out_rdy = 1'b1;
    credits = 5;
    model_reset();
    #3;
    checks++; if (enq_rdy !== 1'b1) begin failures++; $display("FAIL reset_enq_rdy got=%b exp=1", enq_rdy); end
    checks++; if (out_ena !== 1'b0) begin failures++; $display("FAIL reset_out_ena got=%b exp=0", out_ena); end
    checks++; if (dec_ena !== 1'b0) begin failures++; $display("FAIL reset_dec_ena got=%b exp=0", dec_ena); end
    checks++; if (inc_ena !== 1'b0) begin failures++; $display("FAIL reset_inc_ena got=%b exp=0", inc_ena); end
    checks++; if (inc_v !== '0)     begin failures++; $display("FAIL reset_inc_v got=%0d exp=0", inc_v); end
    checks++; if (ovf !== 1'b0)     begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    @(negedge clk) nrst = 1'b1;
    @(posedge clk);
    #1;
    $display("reset released at cycle %0d", cyc);
  endtask

  task automatic test_basic_send();
    int sends = 0;
    do_reset();
    credits = 3;
    out_rdy = 1'b1;
    for (int i = 0; i < 7; i++) begin
      enq_ena = (i < 4);
      enq_v   = $urandom;
      @(negedge clk);
      predict();
      checks++; if (enq_rdy !== e_enq_rdy) begin failures++; $display("FAIL basic_enq_rdy cyc=%0d got=%b exp=%b", i, enq_rdy, e_enq_rdy); end
      checks++; if (out_ena !== e_out_ena) begin failures++; $display("FAIL basic_out_ena cyc=%0d got=%b exp=%b", i, out_ena, e_out_ena); end
      checks++; if (dec_ena !== e_out_ena) begin failures++; $display("FAIL basic_dec_ena cyc=%0d got=%b exp=%b", i, dec_ena, e_out_ena); end
      if (e_out_ena) begin
        checks++; if (out_v !== e_out_v) begin failures++; $display("FAIL basic_out_v cyc=%0d got=%h exp=%h", i, out_v, e_out_v); end
        checks++; if (dec_v !== 10'd1)   begin failures++; $display("FAIL basic_dec_v cyc=%0d got=%0d exp=1", i, dec_v); end
      end
      if (out_ena === 1'b1) begin
        sends++;
        $display("send cyc=%0d data=%h", i, out_v);
      end
      advance();
    end
    checks++; if (sends != 3) begin failures++; $display("FAIL basic_send_count got=%0d exp=3", sends); end
  endtask

  task automatic test_full_fifo();
    do_reset();
    credits = 5;
    for (int i = 0; i < 10; i++) begin
      enq_ena = (i <= 4);
      enq_v   = $urandom;
      out_rdy = (i == 4) || (i >= 6);
      @(negedge clk);
      predict();
      checks++; if (enq_rdy !== e_enq_rdy) begin failures++; $display("FAIL full_enq_rdy cyc=%0d got=%b exp=%b", i, enq_rdy, e_enq_rdy); end
      checks++; if (out_ena !== e_out_ena) begin failures++; $display("FAIL full_out_ena cyc=%0d got=%b exp=%b", i, out_ena, e_out_ena); end
      if (e_out_ena) begin
        checks++; if (out_v !== e_out_v) begin failures++; $display("FAIL full_out_v cyc=%0d got=%h exp=%h", i, out_v, e_out_v); end
      end
      if (i == 4) begin
        checks++; if (enq_rdy !== 1'b0) begin failures++; $display("FAIL full_when_full got=%b exp=0", enq_rdy); end
      end
      if (i == 5) begin
        checks++; if (enq_rdy !== 1'b1) begin failures++; $display("FAIL full_after_pop got=%b exp=1", enq_rdy); end
      end
      if (out_ena === 1'b1) $display("send cyc=%0d data=%h", i, out_v);
      advance();
    end
  endtask

  task automatic test_threshold_flush();
    int fc = -1;
    logic [CSZ-1:0] fv = '0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cr_ena = (i < 2);
      cr_v   = (i == 0) ? 10'd3 : 10'd2;
      @(negedge clk);
      predict();
      checks++; if (inc_ena !== e_inc_ena) begin failures++; $display("FAIL thr_inc_ena cyc=%0d got=%b exp=%b", i, inc_ena, e_inc_ena); end
      if (e_inc_ena) begin
        checks++; if (inc_v !== CSZ'(m_acc)) begin failures++; $display("FAIL thr_inc_v cyc=%0d got=%0d exp=%0d", i, inc_v, m_acc); end
      end
      if (inc_ena === 1'b1 && fc < 0) begin
        fc = i; fv = inc_v;
        $display("flush cyc=%0d credits=%0d", i, inc_v);
      end
      advance();
    end
    checks++; if (fc != 2)     begin failures++; $display("FAIL thr_flush_cycle got=%0d exp=2", fc); end
    checks++; if (fv !== 10'd5) begin failures++; $display("FAIL thr_flush_value got=%0d exp=5", fv); end
  endtask

  task automatic test_timeout_flush();
    int fc = -1;
    logic [CSZ-1:0] fv = '0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cr_ena = (i == 0);
      cr_v   = 10'd1;
      @(negedge clk);
      predict();
      checks++; if (inc_ena !== e_inc_ena) begin failures++; $display("FAIL tmo_inc_ena cyc=%0d got=%b exp=%b", i, inc_ena, e_inc_ena); end
      if (inc_ena === 1'b1 && fc < 0) begin
        fc = i; fv = inc_v;
        $display("flush cyc=%0d credits=%0d", i, inc_v);
      end
      advance();
    end
    checks++; if (fc != TMO)    begin failures++; $display("FAIL tmo_flush_cycle got=%0d exp=%0d", fc, TMO); end
    checks++; if (fv !== 10'd1) begin failures++; $display("FAIL tmo_flush_value got=%0d exp=1", fv); end
  endtask

  task automatic test_back_pressure();
    do_reset();
    for (int i = 0; i < 13; i++) begin
      inc_rdy = (i >= 2);
      cr_ena  = (i <= 2);
      cr_v    = (i == 0) ? 10'd4 : (i == 1) ? 10'd2 : 10'd3;
      @(negedge clk);
      predict();
      checks++; if (inc_ena !== e_inc_ena) begin failures++; $display("FAIL bp_inc_ena cyc=%0d got=%b exp=%b", i, inc_ena, e_inc_ena); end
      if (i == 2) begin
        checks++; if (inc_v !== 10'd6) begin failures++; $display("FAIL bp_release_v got=%0d exp=6", inc_v); end
      end
      if (i == 10) begin
        checks++; if (inc_ena !== 1'b1 || inc_v !== 10'd3) begin failures++; $display("FAIL bp_new_acc ena=%b v=%0d exp ena=1 v=3", inc_ena, inc_v); end
      end
      if (inc_ena === 1'b1) $display("flush cyc=%0d credits=%0d", i, inc_v);
      advance();
    end
  endtask

  task automatic test_saturation_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      inc_rdy = (i == 3) || (i == 8);
      cr_ena  = (i <= 1) || (i == 7);
      cr_v    = (i == 0) ? 10'd1020 : (i == 1) ? 10'd10 : 10'd5;
      enq_ena = (i >= 4) && (i <= 6);
      enq_v   = $urandom;
      out_rdy = (i >= 7);
      if (i == 4) credits = 2;
      @(negedge clk);
      predict();
      checks++; if (ovf !== m_ovf)         begin failures++; $display("FAIL sat_ovf cyc=%0d got=%b exp=%b", i, ovf, m_ovf); end
      checks++; if (inc_ena !== e_inc_ena) begin failures++; $display("FAIL sat_inc_ena cyc=%0d got=%b exp=%b", i, inc_ena, e_inc_ena); end
      checks++; if (out_ena !== e_out_ena) begin failures++; $display("FAIL sat_out_ena cyc=%0d got=%b exp=%b", i, out_ena, e_out_ena); end
      if (i == 2) begin
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL sat_flag got=%b exp=1", ovf); end
      end
      if (i == 3) begin
        checks++; if (inc_v !== 10'd1023) begin failures++; $display("FAIL sat_value got=%0d exp=1023", inc_v); end
      end
      if (i == 8) begin
        checks++; if (out_ena !== 1'b1 || inc_ena !== 1'b1) begin failures++; $display("FAIL sat_midstream out=%b inc=%b exp 1 1", out_ena, inc_ena); end
        break;
      end
      advance();
    end
    // asynchronous reset in the middle of a cycle, no clock edge in between
    #1 nrst = 1'b0;
    #1;
    checks++; if (enq_rdy !== 1'b1) begin failures++; $display("FAIL async_enq_rdy got=%b exp=1", enq_rdy); end
    checks++; if (out_ena !== 1'b0) begin failures++; $display("FAIL async_out_ena got=%b exp=0", out_ena); end
    checks++; if (dec_ena !== 1'b0) begin failures++; $display("FAIL async_dec_ena got=%b exp=0", dec_ena); end
    checks++; if (inc_ena !== 1'b0) begin failures++; $display("FAIL async_inc_ena got=%b exp=0", inc_ena); end
    checks++; if (inc_v !== '0)     begin failures++; $display("FAIL async_inc_v got=%0d exp=0", inc_v); end
    checks++; if (ovf !== 1'b0)     begin failures++; $display("FAIL async_ovf got=%b exp=0", ovf); end
    $display("async reset applied mid-cycle");
    model_reset();
    idle_inputs();
    credits = 0;
    @(negedge clk) nrst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    do_reset();
    credits = 4;
    for (int i = 0; i < 400; i++) begin
      enq_ena = ($urandom_range(0, 99) < 60);
      enq_v   = $urandom;
      out_rdy = ($urandom_range(0, 99) < 75);
      dec_rdy = ($urandom_range(0, 99) < 90);
      rd_rdy  = ($urandom_range(0, 99) < 90);
      inc_rdy = ($urandom_range(0, 99) < 70);
      cr_ena  = (credits < 900) && ($urandom_range(0, 99) < 30);
      cr_v    = CSZ'($urandom_range(0, 5));
      @(negedge clk);
      predict();
      checks++; if (enq_rdy !== e_enq_rdy) begin failures++; $display("FAIL rnd_enq_rdy cyc=%0d got=%b exp=%b", i, enq_rdy, e_enq_rdy); end
      checks++; if (out_ena !== e_out_ena) begin failures++; $display("FAIL rnd_out_ena cyc=%0d got=%b exp=%b", i, out_ena, e_out_ena); end
      checks++; if (dec_ena !== e_out_ena) begin failures++; $display("FAIL rnd_dec_ena cyc=%0d got=%b exp=%b", i, dec_ena, e_out_ena); end
      checks++; if (inc_ena !== e_inc_ena) begin failures++; $display("FAIL rnd_inc_ena cyc=%0d got=%b exp=%b", i, inc_ena, e_inc_ena); end
      checks++; if (ovf !== m_ovf)         begin failures++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", i, ovf, m_ovf); end
      if (e_out_ena) begin
        checks++; if (out_v !== e_out_v) begin failures++; $display("FAIL rnd_out_v cyc=%0d got=%h exp=%h", i, out_v, e_out_v); end
        checks++; if (dec_v !== 10'd1)   begin failures++; $display("FAIL rnd_dec_v cyc=%0d got=%0d exp=1", i, dec_v); end
      end
      if (e_inc_ena) begin
        checks++; if (inc_v !== CSZ'(m_acc)) begin failures++; $display("FAIL rnd_inc_v cyc=%0d got=%0d exp=%0d", i, inc_v, m_acc); end
      end
      if (out_ena === 1'b1) $display("send cyc=%0d data=%h", i, out_v);
      if (inc_ena === 1'b1) $display("flush cyc=%0d credits=%0d", i, inc_v);
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_basic_send();
    test_full_fifo();
    test_threshold_flush();
    test_timeout_flush();
    test_back_pressure();
    test_saturation_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
